// File: rtl/ucie_ctl_tx_fsm.sv
// ucie_ctl_tx_fsm: credit-gated transmit control FSM feeding the UCIe TX datapath
module ucie_ctl_tx_fsm #(
  parameter int FLIT_W      = 256,
  parameter int MAX_CREDITS = 8,
  parameter int CREDIT_W    = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_state_request,
  input  logic                i_rx_overflow,
  input  logic                i_credit_return,
  input  logic                i_flit_valid,
  input  logic [FLIT_W-1:0]   i_flit_data,
  output logic                o_flit_ready,
  output logic                o_tx_valid,
  output logic [FLIT_W-1:0]   o_tx_data,
  output logic                o_tx_enable,
  output logic [CREDIT_W-1:0] o_credit_count,
  output logic                o_error
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;
  localparam logic [CREDIT_W-1:0] C_MAX = CREDIT_W'(MAX_CREDITS);
  localparam logic [CREDIT_W-1:0] C_ONE = CREDIT_W'(1);
  logic [1:0]          r_state;
  logic [1:0]          w_next;
  logic [CREDIT_W-1:0] r_credits;
  logic                r_tx_valid;
  logic [FLIT_W-1:0]   r_tx_data;
  logic                w_live;
  logic                w_full;
  logic                w_accept;
  logic                w_over;
  logic                w_err;
  assign w_live         = r_state == S_ACTIVE || r_state == S_DRAIN;
  assign w_full         = r_credits == C_MAX;
  assign o_flit_ready   = r_state == S_ACTIVE && r_credits != '0;
  assign w_accept       = i_flit_valid && o_flit_ready;
  assign w_over         = w_live && i_credit_return && w_full && !w_accept;
  assign w_err          = w_live && (i_rx_overflow || w_over);
  assign o_tx_enable    = w_live;
  assign o_error        = r_state == S_ERROR;
  assign o_tx_valid     = r_tx_valid;
  assign o_tx_data      = r_tx_data;
  assign o_credit_count = r_credits;
  // next state: errors outrank request changes; drain finishes once all credits are home
  always_comb begin
    w_next = r_state == S_IDLE  ? (i_state_request ? S_ACTIVE : S_IDLE) :
             r_state == S_ERROR ? (i_state_request ? S_ERROR : S_IDLE) :
             w_err              ? S_ERROR :
             i_state_request    ? S_ACTIVE :
             r_state == S_ACTIVE ? S_DRAIN :
             w_full             ? S_IDLE : S_DRAIN;
  end
  // state and credit counter; an over-return holds the count, ERROR freezes it
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= S_IDLE;
      r_credits <= C_MAX;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE || w_next == S_IDLE) r_credits <= C_MAX;
      else if (w_accept && !i_credit_return) r_credits <= r_credits - C_ONE;
      else if (w_live && i_credit_return && !w_accept && !w_full) r_credits <= r_credits + C_ONE;
    end
  end
  // one-cycle registered flit strobe; payload holds between accepts
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_valid <= w_accept;
      if (w_accept) r_tx_data <= i_flit_data;
    end
  end
endmodule

// File: tb/tb_ucie_ctl_tx_fsm.sv
// tb_ucie_ctl_tx_fsm: directed vector table, corner sequences and random run against a reference model
module tb_ucie_ctl_tx_fsm;
  localparam int FLIT_W = 256;
  localparam int MAXC   = 8;
  logic              clk, rst_n, req, ovf, ret, fv;
  logic [FLIT_W-1:0] fd;
  logic              rdy, tv, en, err;
  logic [FLIT_W-1:0] td;
  logic [3:0]        cc;
  int checks = 0;
  int errors = 0;
  typedef enum {M_IDLE, M_ACT, M_DRAIN, M_ERR} mode_t;
  mode_t             m_mode;
  int                m_cred;
  bit                m_val;
  logic [FLIT_W-1:0] m_data;
  typedef struct {int r, o, c, v, d, rdy, val, dat, cr, en, err;} vec_t;
  vec_t tbl[$];

  ucie_ctl_tx_fsm #(.FLIT_W(FLIT_W), .MAX_CREDITS(MAXC), .CREDIT_W(4)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_state_request(req), .i_rx_overflow(ovf),
    .i_credit_return(ret), .i_flit_valid(fv), .i_flit_data(fd),
    .o_flit_ready(rdy), .o_tx_valid(tv), .o_tx_data(td), .o_tx_enable(en),
    .o_credit_count(cc), .o_error(err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [FLIT_W-1:0] a, input logic [FLIT_W-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_cred = MAXC;
    m_val  = 1'b0;
    m_data = '0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " ready"},  FLIT_W'(rdy), FLIT_W'(m_mode == M_ACT && m_cred > 0));
    chk({tag, " valid"},  FLIT_W'(tv),  FLIT_W'(m_val));
    chk({tag, " data"},   td,           m_data);
    chk({tag, " enable"}, FLIT_W'(en),  FLIT_W'(m_mode == M_ACT || m_mode == M_DRAIN));
    chk({tag, " credit"}, FLIT_W'(cc),  FLIT_W'(m_cred));
    chk({tag, " error"},  FLIT_W'(err), FLIT_W'(m_mode == M_ERR));
  endtask

  // drive one cycle, advance the model by the specification rules, compare after the edge
  task automatic step(input bit r, input bit o, input bit c, input bit v, input logic [FLIT_W-1:0] d);
    bit acc, live, over, errc;
    mode_t nm;
    req = r; ovf = o; ret = c; fv = v; fd = d;
    acc  = v && m_mode == M_ACT && m_cred > 0;
    live = m_mode == M_ACT || m_mode == M_DRAIN;
    over = live && c && m_cred == MAXC && !acc;
    errc = live && (o || over);
    case (m_mode)
      M_IDLE:  nm = r ? M_ACT : M_IDLE;
      M_ERR:   nm = r ? M_ERR : M_IDLE;
      default: nm = errc ? M_ERR : r ? M_ACT : m_mode == M_ACT ? M_DRAIN : m_cred == MAXC ? M_IDLE : M_DRAIN;
    endcase
    @(posedge clk);
    #1;
    if (m_mode == M_IDLE || nm == M_IDLE) m_cred = MAXC;
    else if (live) m_cred = m_cred + int'(c && !over) - int'(acc);
    m_mode = nm;
    m_val  = acc;
    if (acc) m_data = d;
    chk_model("model");
  endtask

  initial begin
    rst_n = 1'b0; req = 0; ovf = 0; ret = 0; fv = 0; fd = '0;
    model_reset();
    tbl.push_back('{1,0,0,0,0,    1,0,0,8,1,0});
    for (int k = 1; k <= 8; k++) tbl.push_back('{1,0,0,1,k, int'(k < 8),1,k,8-k,1,0});
    tbl.push_back('{1,0,0,1,9,    0,0,8,0,1,0});
    for (int k = 1; k <= 5; k++) tbl.push_back('{1,0,1,0,0, 1,0,8,k,1,0});
    tbl.push_back('{1,0,1,1,'h55, 1,1,'h55,5,1,0});
    tbl.push_back('{0,0,0,1,'h66, 0,1,'h66,4,1,0});
    for (int k = 5; k <= 8; k++) tbl.push_back('{0,0,1,0,0, 0,0,'h66,k,1,0});
    tbl.push_back('{0,0,0,0,0,    0,0,'h66,8,0,0});
    tbl.push_back('{1,0,0,0,0,    1,0,'h66,8,1,0});
    tbl.push_back('{1,1,0,1,'h77, 0,1,'h77,7,0,1});
    tbl.push_back('{1,0,1,0,0,    0,0,'h77,7,0,1});
    tbl.push_back('{0,0,0,0,0,    0,0,'h77,8,0,0});
    tbl.push_back('{1,0,0,0,0,    1,0,'h77,8,1,0});
    tbl.push_back('{1,0,1,0,0,    0,0,'h77,8,0,1});
    tbl.push_back('{0,0,0,0,0,    0,0,'h77,8,0,0});
    tbl.push_back('{1,0,0,0,0,    1,0,'h77,8,1,0});
    tbl.push_back('{1,0,0,1,'hA1, 1,1,'hA1,7,1,0});
    tbl.push_back('{0,0,0,0,0,    0,0,'hA1,7,1,0});
    tbl.push_back('{1,0,0,0,0,    1,0,'hA1,7,1,0});
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready",  FLIT_W'(rdy), '0);
    chk("reset valid",  FLIT_W'(tv),  '0);
    chk("reset data",   td,           '0);
    chk("reset enable", FLIT_W'(en),  '0);
    chk("reset credit", FLIT_W'(cc),  FLIT_W'(8));
    chk("reset error",  FLIT_W'(err), '0);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      step(tbl[i].r[0], tbl[i].o[0], tbl[i].c[0], tbl[i].v[0], FLIT_W'(tbl[i].d));
      chk($sformatf("row%0d ready", i),  FLIT_W'(rdy), FLIT_W'(tbl[i].rdy));
      chk($sformatf("row%0d valid", i),  FLIT_W'(tv),  FLIT_W'(tbl[i].val));
      chk($sformatf("row%0d data", i),   td,           FLIT_W'(tbl[i].dat));
      chk($sformatf("row%0d credit", i), FLIT_W'(cc),  FLIT_W'(tbl[i].cr));
      chk($sformatf("row%0d enable", i), FLIT_W'(en),  FLIT_W'(tbl[i].en));
      chk($sformatf("row%0d error", i),  FLIT_W'(err), FLIT_W'(tbl[i].err));
    end
    step(1, 0, 0, 1, FLIT_W'('hB1));
    step(1, 0, 0, 1, FLIT_W'('hB2));
    chk("stream valid", FLIT_W'(tv), FLIT_W'(1));
    chk("stream credit", FLIT_W'(cc), FLIT_W'(5));
    #3 rst_n = 1'b0;
    #1;
    chk("async valid",  FLIT_W'(tv),  '0);
    chk("async data",   td,           '0);
    chk("async credit", FLIT_W'(cc),  FLIT_W'(8));
    chk("async ready",  FLIT_W'(rdy), '0);
    chk("async enable", FLIT_W'(en),  '0);
    req = 0; fv = 0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 4000; n++)
      step($urandom_range(9) != 0, $urandom_range(63) == 0, $urandom_range(3) == 0,
           $urandom_range(4) < 3, {8{$urandom()}});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ucie_ctl_tx_fsm.md
# ucie_ctl_tx_fsm

Transmit-side control FSM of the UCIe controller, the counterpart of the RX FSM/buffer. It gates outgoing flits on the link state request and tracks receiver buffer space with a credit counter, so the far-end RX buffer is never overrun. It also enters a sticky error state when the RX side reports overflow or when the credit protocol is violated. It sits between the protocol-layer flit source and the TX datapath.

## Interface
- FLIT_W, 256, flit data width
- MAX_CREDITS, 8, RX buffer depth in flits; initial and maximum credit count
- CREDIT_W, 4, credit counter width; must hold MAX_CREDITS
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, asynchronous, active-low
- i_state_request  in  1  1 = link active requested; 0 = go idle
- i_rx_overflow  in  1  overflow indication from the RX side
- i_credit_return  in  1  one-cycle pulse; returns one credit
- i_flit_valid  in  1  source has a flit
- i_flit_data  in  FLIT_W  flit payload
- o_flit_ready  out  1  flit accepted when i_flit_valid && o_flit_ready
- o_tx_valid  out  1  registered flit strobe to the TX datapath
- o_tx_data  out  FLIT_W  registered flit payload
- o_tx_enable  out  1  TX path enabled (ACTIVE or DRAIN)
- o_credit_count  out  CREDIT_W  current credits
- o_error  out  1  sticky error flag (ERROR state)

## Operation
- States: IDLE, ACTIVE, DRAIN, ERROR (registered).
- IDLE: credits forced to MAX_CREDITS; i_credit_return is ignored. Goes to ACTIVE when i_state_request=1.
- ACTIVE: o_flit_ready = (credits != 0). Transitions, in priority order:
  - i_rx_overflow=1 → ERROR.
  - i_credit_return while credits == MAX_CREDITS with no accept in the same cycle → ERROR.
  - i_state_request=0 → DRAIN.
- DRAIN: o_flit_ready=0; credit returns are counted. Transitions, in priority order:
  - overflow or an over-return (same rule as ACTIVE) → ERROR.
  - i_state_request=1 → ACTIVE.
  - credits == MAX_CREDITS → IDLE.
- ERROR: o_flit_ready=0, o_tx_enable=0, o_error=1; credits and returns are frozen. Goes to IDLE when i_state_request=0, which reloads credits and clears o_error.
- Credit arithmetic, per cycle in ACTIVE/DRAIN:
  - accept only: credits −1.
  - return only: credits +1.
  - accept and return in the same cycle: unchanged.
  - No wrap: a decrement at 0 is impossible because ready is low at 0; an increment past MAX_CREDITS is the over-return error above and the counter holds.
- Datapath: on an accept, o_tx_data ← i_flit_data and o_tx_valid=1 on the next cycle. Otherwise o_tx_valid=0 and o_tx_data holds its value.
- o_tx_enable = (state == ACTIVE || state == DRAIN).

## Timing
- Reset (i_rst=0, asynchronous):
  - state IDLE, credits MAX_CREDITS.
  - o_tx_valid=0, o_tx_data=0, o_flit_ready=0, o_tx_enable=0, o_error=0.
  - Reset mid-stream discards any in-flight flit immediately.
- IDLE→ACTIVE: request sampled at edge N; o_tx_enable=1 and o_flit_ready=1 after edge N.
- Accept latency is one cycle: a flit accepted at edge N appears on o_tx_valid/o_tx_data after edge N, for one cycle. Back-to-back accepts give a continuous o_tx_valid stream.
- o_flit_ready is a function of registered state and credits only (no combinational path from i_flit_valid).
- Credit update is visible on o_credit_count the cycle after the event. o_flit_ready rises the cycle after a return arrives at 0 credits.
- ERROR entry: o_error=1 and o_flit_ready=0 the cycle after i_rx_overflow. An accept in that same sampling cycle still completes (o_tx_valid=1 once).
- The last accepted flit in ACTIVE appears on o_tx_valid in the first DRAIN cycle.

## Test plan
- Reset/activation: hold i_rst=0 → every output at its reset value and o_credit_count=8. Release reset, set request=1 → next cycle o_tx_enable=1, o_flit_ready=1.
- Credit exhaustion: 8 back-to-back flits (data 1..8), no returns → o_tx_valid high 8 cycles carrying 1..8 in order, credits 0, ready low. One return pulse → credits 1 and ready=1 the next cycle.
- Simultaneous events: credits=5, accept and return in the same cycle → credits stay 5 and o_tx_valid=1.
- Drain: 3 flits outstanding (credits 5), drop request → DRAIN (ready 0, enable 1). Three returns → credits 8, then IDLE with enable 0. Re-raising request during DRAIN → ACTIVE.
- Errors: i_rx_overflow=1 in ACTIVE → ERROR next cycle (o_error 1, enable 0, credits frozen). Separately, a return at credits=8 → ERROR. In both cases request=0 → IDLE with o_error 0 and credits 8.
- Async reset mid-stream: assert i_rst=0 between clock edges during a flit stream → o_tx_valid drops to 0 immediately and credits=8 without waiting for a clock edge.
